// File: rtl/read_iq.sv
// Assembles little-endian 16-bit I/Q samples from a byte FIFO and emits them,
// left-shifted by QUANT_BITS, as one simultaneous write to the I and Q FIFOs.
module read_iq #(
    parameter int QUANT_BITS = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [7:0]            in_dout,
    input  logic                  in_empty,
    output logic                  in_rd_en,
    output logic [DATA_WIDTH-1:0] i_out,
    output logic [DATA_WIDTH-1:0] q_out,
    output logic                  i_wr_en,
    output logic                  q_wr_en,
    input  logic                  i_full,
    input  logic                  q_full
);

    typedef enum logic {
        S_READ  = 1'b0,
        S_WRITE = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [7:0]            byte_q [3];
    logic [DATA_WIDTH-1:0] i_out_q, i_out_d;
    logic [DATA_WIDTH-1:0] q_out_q, q_out_d;
    logic                  consume;
    logic                  emit;

    function automatic logic [DATA_WIDTH-1:0] quantize(input logic [15:0] sample);
        logic [DATA_WIDTH-1:0] ext;
        ext = DATA_WIDTH'($signed(sample));
        return ext << QUANT_BITS;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        i_out_d = i_out_q;
        q_out_d = q_out_q;
        consume = 1'b0;
        emit    = 1'b0;
        case (state_q)
            S_READ: begin
                if (!in_empty) begin
                    consume = 1'b1;
                    cnt_d   = cnt_q + 2'd1;
                    // byte3 arrives straight from the FIFO, so the pair is built this cycle
                    if (cnt_q == 2'd3) begin
                        state_d = S_WRITE;
                        i_out_d = quantize({byte_q[1], byte_q[0]});
                        q_out_d = quantize({in_dout, byte_q[2]});
                    end
                end
            end
            S_WRITE: begin
                if (!i_full && !q_full) begin
                    emit    = 1'b1;
                    state_d = S_READ;
                end
            end
            default: state_d = S_READ;
        endcase
    end

    // Strobes are gated by reset so nothing is popped or pushed while it is held low.
    assign in_rd_en = reset & consume;
    assign i_wr_en  = reset & emit;
    assign q_wr_en  = reset & emit;
    assign i_out    = i_out_q;
    assign q_out    = q_out_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_READ;
            cnt_q   <= 2'd0;
            i_out_q <= '0;
            q_out_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            i_out_q <= i_out_d;
            q_out_q <= q_out_d;
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < 3; i++) begin
            if (!reset) begin
                byte_q[i] <= 8'd0;
            end else if (consume && cnt_q == 2'(i)) begin
                byte_q[i] <= in_dout;
            end
        end
    end

endmodule
